// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the datapath sequencer: state encoding,
// opcodes, ALU function codes, IR field positions and the control word.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LD   = 4'hC;
  localparam logic [3:0] OP_ST   = 4'hD;
  localparam logic [3:0] OP_BZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU function codes for straight transfers of the A or B operand
  localparam logic [3:0] FS_PASS_A = 4'h0;
  localparam logic [3:0] FS_PASS_B = 4'hC;

  // IR layout: op | DR | SA | SB
  localparam int IR_OP_LSB = 12;
  localparam int IR_DR_LSB = 8;
  localparam int IR_SA_LSB = 4;
  localparam int IR_SB_LSB = 0;

  function automatic logic [3:0] ir_op(input logic [15:0] ir);
    return ir[IR_OP_LSB +: 4];
  endfunction

  function automatic logic [3:0] ir_dr(input logic [15:0] ir);
    return ir[IR_DR_LSB +: 4];
  endfunction

  function automatic logic [3:0] ir_sa(input logic [15:0] ir);
    return ir[IR_SA_LSB +: 4];
  endfunction

  function automatic logic [3:0] ir_sb(input logic [15:0] ir);
    return ir[IR_SB_LSB +: 4];
  endfunction

  // Control word produced by the decoder for the current cycle.
  // ir_load marks a completed fetch; br_take marks a taken BZ.
  typedef struct packed {
    logic [3:0] dr;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [3:0] fs;
    logic       mb;
    logic       mm;
    logic       md;
    logic       rw;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       ir_load;
    logic       br_take;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decoder: (state, IR, Z, mem_ready) -> ctrl_t.
module ctrl_decode
  import datapath_ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [15:0] i_ir,
  input  logic        i_z,
  input  logic        i_mem_ready,
  output ctrl_t       o_ctrl
);

  logic [3:0] w_op;
  assign w_op = ir_op(i_ir);

  // Moore-style decode; only the LD write strobe and fetch/branch flags see inputs
  always_comb begin
    o_ctrl    = '0;
    o_ctrl.mm = 1'b1;
    if (i_state != IDLE && i_state != FETCH) begin
      o_ctrl.dr = ir_dr(i_ir);
      o_ctrl.sa = ir_sa(i_ir);
      o_ctrl.sb = ir_sb(i_ir);
    end
    case (i_state)
      FETCH: begin
        o_ctrl.mem_rd  = 1'b1;
        o_ctrl.ir_load = i_mem_ready;
      end
      EXEC: begin
        if (!w_op[3]) begin
          o_ctrl.fs = w_op;
          o_ctrl.rw = 1'b1;
        end else if (w_op[3:2] == 2'b10) begin
          // immediate: B operand becomes {8'b0, SA, SB}
          o_ctrl.fs = {2'b00, w_op[1:0]};
          o_ctrl.mb = 1'b1;
          o_ctrl.rw = 1'b1;
        end else if (w_op == OP_BZ) begin
          o_ctrl.fs      = FS_PASS_A;
          o_ctrl.br_take = i_z;
        end
      end
      MEM: begin
        o_ctrl.mm = 1'b0;
        if (w_op == OP_LD) begin
          o_ctrl.mem_rd = 1'b1;
          o_ctrl.md     = i_mem_ready;
          o_ctrl.rw     = i_mem_ready;
        end else begin
          o_ctrl.mem_wr = 1'b1;
          o_ctrl.fs     = FS_PASS_B;
        end
      end
      HALT:    o_ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle sequencer: owns PC, IR and the FSM; control word comes from ctrl_decode.
module datapath_controller
  import datapath_ctrl_pkg::*;
#(
  parameter int              PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_main,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     instr_in,
  input  logic            Z,
  input  logic            mem_ready,
  output logic [PC_W-1:0] PC,
  output logic [3:0]      DR,
  output logic [3:0]      SA,
  output logic [3:0]      SB,
  output logic [3:0]      FS,
  output logic            MB,
  output logic            MM,
  output logic            MD,
  output logic            RW,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            halted,
  output logic [2:0]      state_dbg
);

  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [3:0]      w_op;
  logic [3:0]      w_sb;
  logic [PC_W-1:0] w_br_tgt;
  ctrl_t           w_ctrl;

  assign w_op     = ir_op(r_ir);
  assign w_sb     = ir_sb(r_ir);
  assign w_br_tgt = PC_W'({ir_dr(r_ir), w_sb[1:0]});

  ctrl_decode u_dec (
    .i_state     (r_state),
    .i_ir        (r_ir),
    .i_z         (Z),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // State register
  always_ff @(posedge clk_main) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start) w_next = FETCH;
      FETCH:  if (mem_ready) w_next = DECODE;
      DECODE: begin
        if (w_op == OP_LD || w_op == OP_ST) w_next = MEM;
        else if (w_op == OP_HALT)           w_next = HALT;
        else                                w_next = EXEC;
      end
      EXEC:    w_next = FETCH;
      MEM:     if (mem_ready) w_next = FETCH;
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  // PC: increment on fetch completion, overridden by a taken branch
  always_ff @(posedge clk_main) begin
    if (reset)               r_pc <= RESET_PC;
    else if (w_ctrl.br_take) r_pc <= w_br_tgt;
    else if (w_ctrl.ir_load) r_pc <= r_pc + PC_W'(1);
  end

  // IR captures memory data when a fetch completes
  always_ff @(posedge clk_main) begin
    if (reset)               r_ir <= 16'h0;
    else if (w_ctrl.ir_load) r_ir <= instr_in;
  end

  // Output mapping from the decoded control word
  always_comb begin
    PC        = r_pc;
    DR        = w_ctrl.dr;
    SA        = w_ctrl.sa;
    SB        = w_ctrl.sb;
    FS        = w_ctrl.fs;
    MB        = w_ctrl.mb;
    MM        = w_ctrl.mm;
    MD        = w_ctrl.md;
    RW        = w_ctrl.rw;
    mem_rd    = w_ctrl.mem_rd;
    mem_wr    = w_ctrl.mem_wr;
    halted    = w_ctrl.halted;
    state_dbg = r_state;
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Cycle-level scoreboard bench for datapath_controller: stimulus pushes the
// hand-computed expected outputs per cycle, a negedge monitor pops and compares.
module tb_datapath_controller;

  logic        clk_main = 1'b0;
  logic        reset = 1'b1, start = 1'b0, Z = 1'b0, mem_ready = 1'b0;
  logic [15:0] instr_in;
  logic [5:0]  PC;
  logic [3:0]  DR, SA, SB, FS;
  logic        MB, MM, MD, RW, mem_rd, mem_wr, halted;
  logic [2:0]  state_dbg;

  logic [15:0] mem [64];

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  id;
    logic [2:0]  st;
    logic [5:0]  pc;
    logic [6:0]  ctl;   // {mem_rd, mem_wr, RW, MD, MB, MM, halted}
    logic [15:0] regs;  // {FS, DR, SA, SB}
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] step_id = 8'd0;

  localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SH = 3'd5;
  localparam logic [6:0] C_IDLE  = 7'b0000010;
  localparam logic [6:0] C_FETCH = 7'b1000010;
  localparam logic [6:0] C_DEC   = 7'b0000010;
  localparam logic [6:0] C_ALU   = 7'b0010010;
  localparam logic [6:0] C_IMM   = 7'b0010110;
  localparam logic [6:0] C_BZ    = 7'b0000010;
  localparam logic [6:0] C_LDW   = 7'b1000000;
  localparam logic [6:0] C_LDR   = 7'b1011000;
  localparam logic [6:0] C_ST    = 7'b0100000;
  localparam logic [6:0] C_HALT  = 7'b0000011;

  always #5 clk_main = ~clk_main;

  assign instr_in = mem[PC];

  datapath_controller #(.PC_W(6), .RESET_PC(6'd0)) dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .start     (start),
    .instr_in  (instr_in),
    .Z         (Z),
    .mem_ready (mem_ready),
    .PC        (PC),
    .DR        (DR),
    .SA        (SA),
    .SB        (SB),
    .FS        (FS),
    .MB        (MB),
    .MM        (MM),
    .MD        (MD),
    .RW        (RW),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  // Apply this cycle's inputs just after the edge and queue what the DUT should show
  task automatic step(input logic r, input logic s, input logic rdy, input logic zv,
                      input logic [2:0] est, input logic [5:0] epc,
                      input logic [6:0] ectl, input logic [15:0] eregs);
    exp_t e;
    @(posedge clk_main);
    #1;
    reset = r; start = s; mem_ready = rdy; Z = zv;
    step_id = step_id + 8'd1;
    e.id = step_id; e.st = est; e.pc = epc; e.ctl = ectl; e.regs = eregs;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation at the falling edge
  always @(negedge clk_main) begin
    exp_t e;
    logic [6:0]  actl;
    logic [15:0] aregs;
    if (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      actl  = {mem_rd, mem_wr, RW, MD, MB, MM, halted};
      aregs = {FS, DR, SA, SB};
      checks++;
      if (state_dbg !== e.st) begin
        failures++;
        $display("FAIL step%0d state: got %0d want %0d", e.id, state_dbg, e.st);
      end
      checks++;
      if (PC !== e.pc) begin
        failures++;
        $display("FAIL step%0d pc: got %0d want %0d", e.id, PC, e.pc);
      end
      checks++;
      if (actl !== e.ctl) begin
        failures++;
        $display("FAIL step%0d ctl{rd,wr,rw,md,mb,mm,halt}: got %b want %b", e.id, actl, e.ctl);
      end
      checks++;
      if (aregs !== e.regs) begin
        failures++;
        $display("FAIL step%0d regs{fs,dr,sa,sb}: got %h want %h", e.id, aregs, e.regs);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h2312;  // reg ALU op2 DR3 SA1 SB2
    mem[1]  = 16'h8512;  // immediate DR5
    mem[2]  = 16'hC470;  // LD DR4 SA7
    mem[3]  = 16'hD025;  // ST SA2 SB5
    mem[4]  = 16'hE932;  // BZ -> 38 when Z
    mem[38] = 16'hE932;  // BZ not taken
    mem[39] = 16'hEF03;  // BZ -> 63
    mem[63] = 16'hF000;  // HALT, fetch wraps PC to 0

    repeat (2) @(posedge clk_main);

    // reset state, then start
    step(0,0,0,0, SI, 6'd0,  C_IDLE,  16'h0000);
    step(0,1,1,0, SI, 6'd0,  C_IDLE,  16'h0000);
    // register ALU
    step(0,0,1,0, SF, 6'd0,  C_FETCH, 16'h0000);
    step(0,0,1,0, SD, 6'd1,  C_DEC,   16'h0312);
    step(0,0,1,0, SE, 6'd1,  C_ALU,   16'h2312);
    // immediate ALU
    step(0,0,1,0, SF, 6'd1,  C_FETCH, 16'h0000);
    step(0,0,1,0, SD, 6'd2,  C_DEC,   16'h0512);
    step(0,0,1,0, SE, 6'd2,  C_IMM,   16'h0512);
    // LD with three wait cycles
    step(0,0,1,0, SF, 6'd2,  C_FETCH, 16'h0000);
    step(0,0,1,0, SD, 6'd3,  C_DEC,   16'h0470);
    step(0,0,0,0, SM, 6'd3,  C_LDW,   16'h0470);
    step(0,0,0,0, SM, 6'd3,  C_LDW,   16'h0470);
    step(0,0,0,0, SM, 6'd3,  C_LDW,   16'h0470);
    step(0,0,1,0, SM, 6'd3,  C_LDR,   16'h0470);
    // ST with one wait cycle
    step(0,0,1,0, SF, 6'd3,  C_FETCH, 16'h0000);
    step(0,0,0,0, SD, 6'd4,  C_DEC,   16'h0025);
    step(0,0,0,0, SM, 6'd4,  C_ST,    16'hC025);
    step(0,0,1,0, SM, 6'd4,  C_ST,    16'hC025);
    // BZ taken to 38
    step(0,0,1,0, SF, 6'd4,  C_FETCH, 16'h0000);
    step(0,0,1,0, SD, 6'd5,  C_DEC,   16'h0932);
    step(0,0,1,1, SE, 6'd5,  C_BZ,    16'h0932);
    // BZ not taken (Z high during DECODE must not matter)
    step(0,0,1,0, SF, 6'd38, C_FETCH, 16'h0000);
    step(0,0,1,1, SD, 6'd39, C_DEC,   16'h0932);
    step(0,0,1,0, SE, 6'd39, C_BZ,    16'h0932);
    // BZ taken to 63, then fetch at 63 wraps PC to 0
    step(0,0,1,0, SF, 6'd39, C_FETCH, 16'h0000);
    step(0,0,1,0, SD, 6'd40, C_DEC,   16'h0F03);
    step(0,0,1,1, SE, 6'd40, C_BZ,    16'h0F03);
    step(0,0,1,1, SF, 6'd63, C_FETCH, 16'h0000);
    step(0,0,1,0, SD, 6'd0,  C_DEC,   16'h0000);
    // HALT ignores start; reset dominates start
    step(0,1,1,0, SH, 6'd0,  C_HALT,  16'h0000);
    step(0,1,1,0, SH, 6'd0,  C_HALT,  16'h0000);
    step(1,1,1,0, SH, 6'd0,  C_HALT,  16'h0000);
    // restart, run into a stalled LD and reset it
    step(0,1,1,0, SI, 6'd0,  C_IDLE,  16'h0000);
    step(0,0,1,0, SF, 6'd0,  C_FETCH, 16'h0000);
    step(0,0,1,0, SD, 6'd1,  C_DEC,   16'h0312);
    step(0,0,1,0, SE, 6'd1,  C_ALU,   16'h2312);
    step(0,0,1,0, SF, 6'd1,  C_FETCH, 16'h0000);
    step(0,0,1,0, SD, 6'd2,  C_DEC,   16'h0512);
    step(0,0,1,0, SE, 6'd2,  C_IMM,   16'h0512);
    step(0,0,1,0, SF, 6'd2,  C_FETCH, 16'h0000);
    step(0,0,0,0, SD, 6'd3,  C_DEC,   16'h0470);
    step(0,0,0,0, SM, 6'd3,  C_LDW,   16'h0470);
    step(1,0,0,0, SM, 6'd3,  C_LDW,   16'h0470);
    // after reset: IDLE, strobes low, PC back to 0, mem_ready ignored
    step(0,0,1,0, SI, 6'd0,  C_IDLE,  16'h0000);
    step(0,0,1,0, SI, 6'd0,  C_IDLE,  16'h0000);
    step(0,0,0,0, SI, 6'd0,  C_IDLE,  16'h0000);

    // let the monitor drain, bounded
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk_main);
    #6;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
Multi-cycle sequencer for the 16-register datapath. It owns the 6-bit PC and the instruction register, and fetches instructions from the unified memory through the datapath's address mux (MM=1). It decodes each instruction into DR/SA/SB/FS/MB/MM/MD/RW. It also runs the memory read/write handshake for fetch, load and store.

Parameters:
PC_W, 6, program-counter width; must equal datapath PC/AddrOut width
RESET_PC, 0, PC value loaded on reset

Ports:
clk_main  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  leaves IDLE on the first cycle it is seen high
instr_in  in  16  memory read data; same bus as datapath DataIn
Z  in  1  ALU zero flag from datapath
mem_ready  in  1  memory completes the current rd/wr this cycle
PC  out  PC_W  program counter, to datapath PC
DR, SA, SB, FS  out  4 each  datapath register addresses and ALU function
MB, MM, MD, RW  out  1 each  datapath mux selects and register write
mem_rd, mem_wr  out  1 each  memory request strobes, held until mem_ready
halted  out  1  high in HALT state
state_dbg  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk_main. Reset is synchronous and active-high, named reset; it dominates every other input.
- Reset values: state=IDLE, PC=RESET_PC, IR=16'h0. Outputs are RW=0, mem_rd=0, mem_wr=0, MM=1, MB=0, MD=0, FS=0, DR/SA/SB=0, halted=0.
- Instruction format: IR[15:12]=op, IR[11:8]=DR, IR[7:4]=SA, IR[3:0]=SB. DR/SA/SB outputs are driven from IR fields in all states except IDLE/FETCH, where they are 0.
- Control outputs are combinational from state and IR (Moore). PC and IR are registers.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: when start=1, go to FETCH.
- FETCH: MM=1, mem_rd=1.
  - On mem_ready: IR<=instr_in, PC<=PC+1 (wraps 63->0), go to DECODE.
  - Zero-wait is allowed: mem_ready in the first FETCH cycle completes the fetch.
- DECODE: one cycle, no strobes.
  - op 0xC or 0xD goes to MEM.
  - op 0xF goes to HALT.
  - All other ops go to EXEC.
- EXEC, one cycle, then FETCH:
  - op 0x0-0x7 (register ALU): FS=op, MB=0, MD=0, RW=1.
  - op 0x8-0xB (immediate ALU): FS={2'b00,op[1:0]}, MB=1 (B={8'b0,SA,SB}), MD=0, RW=1.
  - op 0xE (BZ): FS=FS_PASS_A, RW=0. If Z=1 then PC<={DR,SB[1:0]}; otherwise PC is unchanged (already incremented).
- MEM, address is R[SA] (MM=0):
  - op 0xC (LD): mem_rd=1. On mem_ready: MD=1, RW=1 in that same cycle (R[DR]<=DataIn), go to FETCH.
  - op 0xD (ST): mem_wr=1, FS=FS_PASS_B, MB=0, MD=0 (DataOut=R[SB]), RW=0. On mem_ready, go to FETCH.
- HALT: all strobes 0, halted=1. Stays in HALT until reset; start is ignored.
- Request rule: mem_rd/mem_wr never both high. A request is held stable until mem_ready. mem_ready outside FETCH/MEM is ignored.
- RW is never asserted in FETCH, DECODE, IDLE or HALT. At most one register write per instruction.
- Reset mid-operation: the next state is IDLE, strobes drop the cycle after reset is sampled, PC=RESET_PC. A pending memory transaction is abandoned.
- PC overflow: an instruction at address 63 increments PC to 0. A branch target overrides the increment.

Decomposition:
- Shared package datapath_ctrl_pkg holds:
  - state enum (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5);
  - opcode constants OP_LD=4'hC, OP_ST=4'hD, OP_BZ=4'hE, OP_HALT=4'hF;
  - ALU codes FS_PASS_A, FS_PASS_B, matching the ALU's FS encoding;
  - IR field slice positions.
- One sub-module, ctrl_decode: purely combinational (state, IR, Z, mem_ready) -> control word. The top keeps the state, PC and IR registers.

Test Plan:
- Reset then start, mem_ready always 1, mem[0]=16'h2312 (op2 DR3 SA1 SB2) -> FETCH at PC=0, DECODE, EXEC with RW=1 FS=2 MB=0 DR=3; PC=1; next FETCH 3 cycles after the first.
- mem[1]=16'h8512 immediate -> EXEC shows MB=1, FS=0, DR=5; B operand = 16'h0012.
- LD 16'hC470 with mem_ready delayed 3 cycles -> mem_rd held 4 cycles with MM=0, SA=7; RW=1 and MD=1 only in the ready cycle.
- ST 16'hD025 -> mem_wr=1, SA=2, SB=5, FS=FS_PASS_B, RW=0; returns to FETCH after mem_ready.
- BZ 16'hE932: Z=1 -> PC=6'b1001_10 (38); repeat with Z=0 -> PC = previous PC+1. Also check the PC=63 fetch wraps to 0.
- Instruction 16'hF000 -> halted=1 and start ignored. Then reset asserted during a stalled MEM cycle -> next cycle IDLE, mem_rd=0, PC=0, halted=0.
